// File: rtl/axi4_jam_regfile_if.sv
// AXI4 (full) bus bundle between the JTAG-to-AXI master and the jam register file.
// Data bus is fixed at 32 bits; address and ID widths are parameters.
interface axi4_jam_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_jam_regfile.sv
// AXI4 burst-capable slave behind the JTAG-to-AXI master: ID, scratch, PMOD in/out,
// cycle counter and a small scratch RAM. Independent write and read FSMs.
module axi4_jam_regfile #(
  parameter int          ADDR_W    = 32,
  parameter int          ID_W      = 1,
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] ID_VALUE  = 32'h4A414D31
) (
  input  logic                aclk,
  input  logic                rst,
  axi4_jam_regfile_if.slave   s_axi,
  input  logic [15:0]         gpio_in,
  output logic [15:0]         gpio_out
);
  localparam int         RAM_AW      = $clog2(RAM_WORDS);
  localparam logic [9:0] RAM_BASE    = 10'h040;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    RG_ID, RG_SCRATCH, RG_GPIN, RG_GPOUT, RG_CYCLES, RG_RAM, RG_NONE
  } region_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // Word index is addr[11:2]; anything outside the map decodes to RG_NONE.
  function automatic region_e decode(input logic [9:0] idx);
    region_e rg;
    case (idx)
      10'd0:   rg = RG_ID;
      10'd1:   rg = RG_SCRATCH;
      10'd2:   rg = RG_GPIN;
      10'd3:   rg = RG_GPOUT;
      10'd4:   rg = RG_CYCLES;
      default: rg = (idx >= RAM_BASE && idx < RAM_BASE + 10'(RAM_WORDS)) ? RG_RAM : RG_NONE;
    endcase
    return rg;
  endfunction

  // Only 32-bit FIXED/INCR bursts are supported.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == BURST_FIXED || burst == BURST_INCR) || size != 3'd2;
  endfunction

  logic [31:0] scratch;
  logic [31:0] cycles;
  logic [15:0] gpio_meta, gpio_sync;
  logic [31:0] ram [RAM_WORDS];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[ADDR_W-1:12], s_axi.awaddr[1:0],
                              s_axi.araddr[ADDR_W-1:12], s_axi.araddr[1:0]};

  // ---------------- write path ----------------
  w_state_e          w_state;
  logic [9:0]        w_idx;
  logic [7:0]        w_len, w_beat;
  logic              w_incr, w_berr;
  logic              w_fire, w_we, w_len_err;
  region_e           w_region;
  logic [1:0]        w_beat_resp;
  logic [RAM_AW-1:0] w_ram_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_fire      = (w_state == W_DATA) && s_axi.wvalid && s_axi.wready;
    w_we        = w_fire && !w_berr && !rst;
    w_region    = decode(w_idx);
    w_ram_idx   = RAM_AW'(w_idx - RAM_BASE);
    w_len_err   = s_axi.wlast ? (w_beat != w_len) : (w_beat >= w_len);
    w_beat_resp = RESP_OKAY;
    if (w_berr || w_len_err) w_beat_resp = RESP_SLVERR;
    if (!w_berr && w_region == RG_NONE) w_beat_resp = RESP_DECERR;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge aclk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bid     <= '0;
      s_axi.bresp   <= RESP_OKAY;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_incr        <= 1'b0;
      w_berr        <= 1'b0;
      scratch       <= '0;
      gpio_out      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi.awready <= 1'b1;
          if (s_axi.awvalid && s_axi.awready) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            s_axi.bid     <= s_axi.awid;
            s_axi.bresp   <= RESP_OKAY;
            w_idx         <= s_axi.awaddr[11:2];
            w_len         <= s_axi.awlen;
            w_beat        <= '0;
            w_incr        <= s_axi.awburst == BURST_INCR;
            w_berr        <= burst_bad(s_axi.awburst, s_axi.awsize);
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            // bresp doubles as the running worst-case response; numeric max orders DECERR>SLVERR>OKAY.
            if (w_beat_resp > s_axi.bresp) s_axi.bresp <= w_beat_resp;
            if (w_incr) w_idx <= w_idx + 10'd1;
            if (w_beat != 8'hFF) w_beat <= w_beat + 8'd1;
            if (s_axi.wlast) begin
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase

      for (int b = 0; b < 4; b++)
        if (w_we && w_region == RG_SCRATCH && s_axi.wstrb[b])
          scratch[8*b +: 8] <= s_axi.wdata[8*b +: 8];
      for (int b = 0; b < 2; b++)
        if (w_we && w_region == RG_GPOUT && s_axi.wstrb[b])
          gpio_out[8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
  end

  // NOTE: the RAM is deliberately not reset so it maps onto memory primitives; contents are undefined at power-up.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < 4; b++)
      if (w_we && w_region == RG_RAM && s_axi.wstrb[b])
        ram[w_ram_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
      cycles    <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      cycles    <= cycles + 32'd1;
    end
  end

  // ---------------- read path ----------------
  r_state_e          r_state;
  logic [9:0]        r_idx;
  logic [7:0]        r_len, r_beat;
  logic              r_incr, r_berr;
  logic [9:0]        rd_idx;
  logic              rd_berr;
  region_e           rd_region;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic [RAM_AW-1:0] rd_ram_idx;

  // In idle the AR channel addresses beat 0; during a burst it is the next beat's word.
  always_comb begin
    if (r_state == R_IDLE) begin
      rd_idx  = s_axi.araddr[11:2];
      rd_berr = burst_bad(s_axi.arburst, s_axi.arsize);
    end else begin
      rd_idx  = r_incr ? r_idx + 10'd1 : r_idx;
      rd_berr = r_berr;
    end
    rd_region  = decode(rd_idx);
    rd_ram_idx = RAM_AW'(rd_idx - RAM_BASE);
    rd_data    = '0;
    rd_resp    = RESP_OKAY;
    if (rd_berr) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_region)
        RG_ID:      rd_data = ID_VALUE;
        RG_SCRATCH: rd_data = scratch;
        RG_GPIN:    rd_data = {16'h0, gpio_sync};
        RG_GPOUT:   rd_data = {16'h0, gpio_out};
        RG_CYCLES:  rd_data = cycles;
        RG_RAM:     rd_data = ram[rd_ram_idx];
        default:    rd_resp = RESP_DECERR;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rid     <= '0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rlast   <= 1'b0;
      r_idx         <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_incr        <= 1'b0;
      r_berr        <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi.arready <= 1'b1;
          if (s_axi.arvalid && s_axi.arready) begin
            s_axi.arready <= 1'b0;
            s_axi.rid     <= s_axi.arid;
            s_axi.rdata   <= rd_data;
            s_axi.rresp   <= rd_resp;
            s_axi.rlast   <= s_axi.arlen == 8'd0;
            s_axi.rvalid  <= 1'b1;
            r_idx         <= rd_idx;
            r_len         <= s_axi.arlen;
            r_beat        <= '0;
            r_incr        <= s_axi.arburst == BURST_INCR;
            r_berr        <= rd_berr;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rvalid && s_axi.rready) begin
            if (s_axi.rlast) begin
              s_axi.rvalid  <= 1'b0;
              s_axi.rlast   <= 1'b0;
              s_axi.arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi.rdata <= rd_data;
              s_axi.rresp <= rd_resp;
              s_axi.rlast <= (r_beat + 8'd1) == r_len;
              r_idx       <= rd_idx;
              r_beat      <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
